// File: rtl/dma_arb_pkg.sv
// Shared types, default widths and helpers for the DMA job arbiter and its bench.
// The job struct uses the default widths; parameterised instances carry their own vectors.
package dma_arb_pkg;

  localparam int DefNumReq         = 4;
  localparam int DefAddrWidth      = 48;
  localparam int DefLenWidth       = 32;
  localparam int DefMaxOutstanding = 4;
  localparam int DefCntWidth       = 32;

  typedef struct packed {
    logic [DefAddrWidth-1:0] src;
    logic [DefAddrWidth-1:0] dst;
    logic [DefLenWidth-1:0]  len;
  } dma_job_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } arb_state_e;

  // Next round-robin start position after granting idx among num requesters.
  function automatic int rr_next(input int idx, input int num);
    return (idx + 1 >= num) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/dma_arb_idx_fifo.sv
// Small FIFO of requester indices, one entry per job in flight, so in-order
// completions can be routed back to whoever issued the job.
module dma_arb_idx_fifo #(
  parameter int Depth = 4,
  parameter int Width = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push,
  input  logic             pop,
  input  logic [Width-1:0] wdata,
  output logic [Width-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CntW = $clog2(Depth + 1);
  localparam logic [PtrW-1:0] LastPtr  = PtrW'(Depth - 1);
  localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wr_ptr;
  logic [PtrW-1:0]  rd_ptr;
  logic [CntW-1:0]  count;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign full    = (count == DepthCnt);
  assign empty   = (count == '0);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap explicitly so non-power-of-two depths work too.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= (wr_ptr == LastPtr) ? '0 : wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == LastPtr) ? '0 : rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dma_job_arbiter.sv
// Round-robin arbiter sharing one DMA job frontend between NumReq requesters,
// with an outstanding-job limit, in-order completion routing and drain support.
module dma_job_arbiter
  import dma_arb_pkg::*;
#(
  parameter int NumReq         = DefNumReq,
  parameter int AddrWidth      = DefAddrWidth,
  parameter int LenWidth       = DefLenWidth,
  parameter int MaxOutstanding = DefMaxOutstanding,
  parameter int CntWidth       = DefCntWidth
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NumReq-1:0]             req_valid_i,
  output logic [NumReq-1:0]             req_ready_o,
  input  logic [NumReq*AddrWidth-1:0]   req_src_i,
  input  logic [NumReq*AddrWidth-1:0]   req_dst_i,
  input  logic [NumReq*LenWidth-1:0]    req_len_i,
  output logic [NumReq-1:0]             cmpl_o,
  output logic                          dma_valid_o,
  input  logic                          dma_ready_i,
  output logic [AddrWidth-1:0]          dma_src_o,
  output logic [AddrWidth-1:0]          dma_dst_o,
  output logic [LenWidth-1:0]           dma_len_o,
  input  logic                          dma_done_i,
  input  logic                          drain_i,
  output logic                          busy_o,
  output logic                          done_o,
  output logic [CntWidth-1:0]           issued_cnt_o,
  output logic                          err_o
);

  localparam int IdxW = $clog2(NumReq);
  localparam int OutW = $clog2(MaxOutstanding + 1);
  localparam logic [OutW-1:0] MaxOut = OutW'(MaxOutstanding);

  // Handshake rules: a requester job moves when req_valid_i[i] & req_ready_o[i];
  // ready depends on valid, never the reverse. The DMA job moves when
  // dma_valid_o & dma_ready_i; dma_valid_o and payload hold until then.

  // FSM state is kept as a named signal for checkers to bind to.
  arb_state_e        state;
  logic [IdxW-1:0]   rr_ptr;
  logic [OutW-1:0]   outstanding;
  logic [IdxW-1:0]   grant;
  logic              found;
  logic              accept;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [IdxW-1:0]   head;
  logic [AddrWidth-1:0] sel_src;
  logic [AddrWidth-1:0] sel_dst;
  logic [LenWidth-1:0]  sel_len;
  logic [NumReq-1:0]    cmpl_next;

  // First valid at or above the pointer wins; otherwise wrap to the lowest valid.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < NumReq; i++) begin
      if (!found && req_valid_i[i] && (IdxW'(i) >= rr_ptr)) begin
        grant = IdxW'(i);
        found = 1'b1;
      end
    end
    for (int i = 0; i < NumReq; i++) begin
      if (!found && req_valid_i[i]) begin
        grant = IdxW'(i);
        found = 1'b1;
      end
    end
  end

  assign accept = (state == ST_IDLE) && !drain_i && (outstanding < MaxOut)
                  && !fifo_full && found;
  assign pop    = dma_done_i && !fifo_empty;

  always_comb begin
    req_ready_o = '0;
    sel_src     = '0;
    sel_dst     = '0;
    sel_len     = '0;
    cmpl_next   = '0;
    for (int i = 0; i < NumReq; i++) begin
      req_ready_o[i] = accept && (grant == IdxW'(i));
      cmpl_next[i]   = pop && (head == IdxW'(i));
      if (grant == IdxW'(i)) begin
        sel_src = req_src_i[i*AddrWidth +: AddrWidth];
        sel_dst = req_dst_i[i*AddrWidth +: AddrWidth];
        sel_len = req_len_i[i*LenWidth +: LenWidth];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state        <= ST_IDLE;
      dma_valid_o  <= 1'b0;
      dma_src_o    <= '0;
      dma_dst_o    <= '0;
      dma_len_o    <= '0;
      issued_cnt_o <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            dma_src_o   <= sel_src;
            dma_dst_o   <= sel_dst;
            dma_len_o   <= sel_len;
            dma_valid_o <= 1'b1;
            state       <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (dma_ready_i) begin
            dma_valid_o <= 1'b0;
            state       <= ST_IDLE;
            if (issued_cnt_o != '1) begin
              issued_cnt_o <= issued_cnt_o + 1'b1;
            end
          end
        end
        default: begin
          dma_valid_o <= 1'b0;
          state       <= ST_IDLE;
        end
      endcase
    end
  end

  // A done that finds nothing in flight is dropped and flagged permanently.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_ptr      <= '0;
      outstanding <= '0;
      cmpl_o      <= '0;
      err_o       <= 1'b0;
    end else begin
      cmpl_o <= cmpl_next;
      if (accept) begin
        rr_ptr <= IdxW'(rr_next(int'(grant), NumReq));
      end
      case ({accept, pop})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
      if (dma_done_i && fifo_empty) begin
        err_o <= 1'b1;
      end
    end
  end

  assign busy_o = (outstanding != '0);
  assign done_o = drain_i && (outstanding == '0) && (state == ST_IDLE);

  dma_arb_idx_fifo #(
    .Depth (MaxOutstanding),
    .Width (IdxW)
  ) u_idx_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push   (accept),
    .pop    (pop),
    .wdata  (grant),
    .rdata  (head),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

endmodule

// File: tb/tb_dma_job_arbiter.sv
// Randomised and directed bench for dma_job_arbiter, checked every cycle
// against a queue-based model of pending jobs and in-flight requester ids.
module tb_dma_job_arbiter;
  import dma_arb_pkg::*;

  localparam int N  = 4;
  localparam int AW = 48;
  localparam int LW = 32;
  localparam int MO = 4;
  localparam int CW = 32;
  localparam int JW = $bits(dma_job_t);

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*AW-1:0] req_src;
  logic [N*AW-1:0] req_dst;
  logic [N*LW-1:0] req_len;
  logic [N-1:0]    cmpl;
  logic            dma_valid;
  logic            dma_ready;
  logic [AW-1:0]   dma_src;
  logic [AW-1:0]   dma_dst;
  logic [LW-1:0]   dma_len;
  logic            dma_done;
  logic            drain;
  logic            busy;
  logic            done;
  logic [CW-1:0]   issued_cnt;
  logic            err;

  dma_job_arbiter #(
    .NumReq(N), .AddrWidth(AW), .LenWidth(LW), .MaxOutstanding(MO), .CntWidth(CW)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_src_i    (req_src),
    .req_dst_i    (req_dst),
    .req_len_i    (req_len),
    .cmpl_o       (cmpl),
    .dma_valid_o  (dma_valid),
    .dma_ready_i  (dma_ready),
    .dma_src_o    (dma_src),
    .dma_dst_o    (dma_dst),
    .dma_len_o    (dma_len),
    .dma_done_i   (dma_done),
    .drain_i      (drain),
    .busy_o       (busy),
    .done_o       (done),
    .issued_cnt_o (issued_cnt),
    .err_o        (err)
  );

  // scoreboard / model state
  int checks = 0;
  int errors = 0;
  logic [JW-1:0] exp_q[$];   // jobs granted but not yet taken by the DMA side
  int            id_q[$];    // requester ids of jobs accepted and not completed
  int            rr = 0;
  logic [CW-1:0] exp_issued = '0;
  logic          exp_err = 1'b0;
  logic [N-1:0]  exp_cmpl = '0;
  int            dut_accepts = 0;
  int            grant_log[$];

  logic [AW-1:0] src_v [N];
  logic [AW-1:0] dst_v [N];
  logic [LW-1:0] len_v [N];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int model_grant(input logic [N-1:0] v);
    int idx;
    for (int k = 0; k < N; k++) begin
      idx = (rr + k) % N;
      if (((v >> idx) & N'(1)) != '0) return idx;
    end
    return -1;
  endfunction

  // driver tasks
  task automatic rand_payload();
    for (int i = 0; i < N; i++) begin
      src_v[i] = AW'({$urandom(), $urandom()});
      dst_v[i] = AW'({$urandom(), $urandom()});
      len_v[i] = $urandom();
    end
  endtask

  task automatic apply(input logic [N-1:0] v, input logic r, input logic d, input logic dr);
    req_valid = v;
    dma_ready = r;
    dma_done  = d;
    drain     = dr;
    for (int i = 0; i < N; i++) begin
      req_src[i*AW +: AW] = src_v[i];
      req_dst[i*AW +: AW] = dst_v[i];
      req_len[i*LW +: LW] = len_v[i];
    end
  endtask

  // Check all outputs against the model, then advance the model across the edge.
  task automatic cycle();
    int g;
    int h;
    logic [N-1:0] exp_ready;
    #1;
    g = -1;
    if (exp_q.size() == 0 && !drain && id_q.size() < MO) g = model_grant(req_valid);
    exp_ready = (g >= 0) ? (N'(1) << g) : '0;
    check("req_ready", req_ready, exp_ready);
    check("dma_valid", dma_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) check("dma_payload", {dma_src, dma_dst, dma_len}, exp_q[0]);
    check("cmpl", cmpl, exp_cmpl);
    check("busy", busy, id_q.size() != 0);
    check("done", done, drain && id_q.size() == 0 && exp_q.size() == 0);
    check("err", err, exp_err);
    check("issued_cnt", issued_cnt, exp_issued);
    for (int i = 0; i < N; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        dut_accepts++;
        grant_log.push_back(i);
      end
    end
    if (!rst_n) begin
      exp_q.delete();
      id_q.delete();
      rr = 0;
      exp_issued = '0;
      exp_err = 1'b0;
      exp_cmpl = '0;
    end else begin
      exp_cmpl = '0;
      if (dma_done) begin
        if (id_q.size() != 0) begin
          h = id_q.pop_front();
          exp_cmpl = N'(1) << h;
        end else begin
          exp_err = 1'b1;
        end
      end
      if (exp_q.size() != 0 && dma_ready) begin
        void'(exp_q.pop_front());
        if (exp_issued != '1) exp_issued = exp_issued + 1;
      end
      if (g >= 0) begin
        exp_q.push_back({src_v[g], dst_v[g], len_v[g]});
        id_q.push_back(g);
        rr = (g + 1) % N;
      end
    end
    @(negedge clk);
  endtask

  task automatic drain_all();
    for (int k = 0; k < 20 && (id_q.size() != 0 || exp_q.size() != 0); k++) begin
      apply('0, 1'b1, id_q.size() != 0, 1'b0);
      cycle();
    end
    apply('0, 1'b1, 1'b0, 1'b0);
    cycle();
  endtask

  initial begin
    logic          prev;
    logic          this_issue;
    logic [CW-1:0] base;
    int            acc0;
    int            first;

    rand_payload();
    apply('0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    cycle();
    check("rst_dma_valid", dma_valid, 1'b0);
    check("rst_issued", issued_cnt, '0);
    check("rst_err", err, 1'b0);
    rst_n = 1'b1;

    // single job from requester 2
    src_v[2] = 48'h1000;
    dst_v[2] = 48'h2000;
    len_v[2] = 32'd64;
    apply(4'b0100, 1'b1, 1'b0, 1'b0);
    cycle();
    check("single_valid", dma_valid, 1'b1);
    check("single_src", dma_src, 48'h1000);
    check("single_dst", dma_dst, 48'h2000);
    check("single_len", dma_len, 32'd64);
    apply('0, 1'b1, 1'b0, 1'b0);
    cycle();
    cycle();
    apply('0, 1'b1, 1'b1, 1'b0);
    cycle();
    check("single_cmpl", cmpl, 4'b0100);
    check("single_issued", issued_cnt, 1);
    check("single_busy", busy, 1'b0);
    apply('0, 1'b1, 1'b0, 1'b0);
    cycle();

    // fairness: everyone valid, done one cycle after each issue
    prev = 1'b0;
    base = exp_issued;
    grant_log.delete();
    for (int k = 0; k < 16; k++) begin
      rand_payload();
      apply('1, 1'b1, prev, 1'b0);
      this_issue = (exp_q.size() != 0);
      cycle();
      prev = this_issue;
    end
    check("fair_jobs", issued_cnt, base + 8);
    check("fair_grants", grant_log.size(), 8);
    first = (grant_log.size() != 0) ? grant_log[0] : 0;
    for (int k = 1; k < grant_log.size(); k++) begin
      check("fair_order", grant_log[k], (first + k) % N);
    end
    apply('0, 1'b1, prev, 1'b0);
    cycle();
    drain_all();

    // backpressure
    rand_payload();
    apply(4'b0010, 1'b0, 1'b0, 1'b0);
    cycle();
    for (int k = 0; k < 5; k++) begin
      rand_payload();
      apply('1, 1'b0, 1'b0, 1'b0);
      cycle();
      check("bp_hold_valid", dma_valid, 1'b1);
      check("bp_ready", req_ready, '0);
    end
    base = exp_issued;
    apply('0, 1'b1, 1'b0, 1'b0);
    cycle();
    check("bp_one_xfer", issued_cnt, base + 1);
    drain_all();

    // outstanding limit
    acc0 = dut_accepts;
    for (int k = 0; k < 12; k++) begin
      rand_payload();
      apply('1, 1'b1, 1'b0, 1'b0);
      cycle();
    end
    check("limit_accepts", dut_accepts - acc0, 4);
    check("limit_ready", req_ready, '0);
    acc0 = dut_accepts;
    apply('1, 1'b1, 1'b1, 1'b0);
    cycle();
    check("limit_done_nogrant", dut_accepts - acc0, 0);
    apply('1, 1'b1, 1'b0, 1'b0);
    cycle();
    check("limit_fifth", dut_accepts - acc0, 1);
    for (int k = 0; k < 6; k++) begin
      rand_payload();
      apply('1, 1'b1, k < 2, 1'b0);
      cycle();
    end
    check("limit_full_again", req_ready, '0);
    check("limit_busy", busy, 1'b1);
    drain_all();

    // drain with two jobs in flight
    rand_payload();
    apply(4'b0001, 1'b1, 1'b0, 1'b0); cycle();
    apply('0, 1'b1, 1'b0, 1'b0);      cycle();
    apply(4'b0100, 1'b1, 1'b0, 1'b0); cycle();
    apply('0, 1'b1, 1'b0, 1'b0);      cycle();
    acc0 = dut_accepts;
    for (int k = 0; k < 4; k++) begin
      apply('1, 1'b1, 1'b0, 1'b1);
      cycle();
    end
    check("drain_no_grant", dut_accepts - acc0, 0);
    check("drain_done_low", done, 1'b0);
    apply('1, 1'b1, 1'b1, 1'b1); cycle();
    apply('1, 1'b1, 1'b0, 1'b1); cycle();
    check("drain_done_mid", done, 1'b0);
    apply('1, 1'b1, 1'b1, 1'b1); cycle();
    check("drain_done_high", done, 1'b1);
    apply('1, 1'b1, 1'b0, 1'b0);
    #1;
    check("drain_release", done, 1'b0);
    cycle();
    drain_all();

    // drain raised while a job waits on the DMA side
    base = exp_issued;
    apply(4'b0001, 1'b0, 1'b0, 1'b0); cycle();
    apply('1, 1'b0, 1'b0, 1'b1);      cycle();
    apply('1, 1'b1, 1'b0, 1'b1);      cycle();
    check("drain_issue_xfer", issued_cnt, base + 1);
    drain_all();

    // random traffic
    for (int k = 0; k < 800; k++) begin
      rand_payload();
      apply(N'($urandom_range(0, 15)), $urandom_range(0, 3) != 0,
            (id_q.size() != 0) && ($urandom_range(0, 2) == 0),
            $urandom_range(0, 15) == 0);
      cycle();
    end
    drain_all();

    // spurious completion
    apply('0, 1'b1, 1'b1, 1'b0); cycle();
    apply('0, 1'b1, 1'b0, 1'b0); cycle();
    check("err_set", err, 1'b1);
    cycle();
    cycle();
    check("err_sticky", err, 1'b1);

    // reset while a job waits in ISSUE
    rand_payload();
    apply(4'b1000, 1'b0, 1'b0, 1'b0); cycle();
    apply('0, 1'b0, 1'b0, 1'b0);      cycle();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    check("rst2_dma_valid", dma_valid, 1'b0);
    check("rst2_issued", issued_cnt, '0);
    check("rst2_err", err, 1'b0);
    check("rst2_busy", busy, 1'b0);
    check("rst2_cmpl", cmpl, '0);
    apply('0, 1'b1, 1'b1, 1'b0); cycle();
    apply('0, 1'b1, 1'b0, 1'b0); cycle();
    check("rst2_late_done_err", err, 1'b1);
    apply('1, 1'b1, 1'b0, 1'b0);
    #1;
    check("rst2_rr_start", req_ready, 4'b0001);
    cycle();
    drain_all();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dma_job_arbiter.md
Name: dma_job_arbiter

Overview:
- Shares one DMA test-node job frontend between NumReq requesters (e.g. traffic generators in a compute-tile bench).
- Round-robin arbitrates job descriptors (src, dst, length) and forwards them through a registered valid/ready port.
- Limits jobs in flight and routes in-order completions back to the requester that issued each job.
- Supports a drain request and raises done_o once drained, which feeds end-of-simulation logic.

Parameters:
- NumReq, 4, number of requesters (>=2).
- AddrWidth, 48, byte-address width of src/dst.
- LenWidth, 32, job length width in bytes.
- MaxOutstanding, 4, max jobs accepted but not yet completed (>=1).
- CntWidth, 32, width of the issued-job statistics counter.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- req_valid_i  in  NumReq  per-requester job valid
- req_ready_o  out  NumReq  per-requester job accept (one-hot or zero)
- req_src_i  in  NumReq*AddrWidth  packed source addresses, requester i at slice i
- req_dst_i  in  NumReq*AddrWidth  packed destination addresses
- req_len_i  in  NumReq*LenWidth  packed lengths
- cmpl_o  out  NumReq  one-cycle completion pulse to the issuing requester
- dma_valid_o  out  1  job valid to DMA frontend (registered)
- dma_ready_i  in  1  DMA frontend accepts job
- dma_src_o  out  AddrWidth  forwarded source
- dma_dst_o  out  AddrWidth  forwarded destination
- dma_len_o  out  LenWidth  forwarded length
- dma_done_i  in  1  one job completed (pulse, in issue order)
- drain_i  in  1  level; stop granting new jobs
- busy_o  out  1  outstanding count != 0
- done_o  out  1  drain_i & outstanding == 0 & state IDLE
- issued_cnt_o  out  CntWidth  jobs handed to DMA, saturating
- err_o  out  1  sticky: dma_done_i while nothing outstanding

Behaviour:
- Reset (rst_ni low at a clock edge): all outputs 0, state IDLE, rr pointer 0, outstanding 0, FIFO empty, err_o 0.
- FSM IDLE:
  - Grant = first i with req_valid_i[i], searching from the rr pointer upward with wrap.
  - req_ready_o[grant] = 1 only if !drain_i and outstanding < MaxOutstanding. This is combinational from req_valid_i, and no valid-to-ready dependency exists on the other side.
  - On accept: latch src/dst/len, push grant index into the completion FIFO, outstanding += 1, rr pointer = (grant+1) mod NumReq, go to ISSUE.
- FSM ISSUE:
  - dma_valid_o = 1; payload stays stable until dma_ready_i.
  - On dma_ready_i: issued_cnt_o += 1, saturating at all-ones; go to IDLE.
  - req_ready_o is all zero in ISSUE.
- Latency and throughput: requester handshake at cycle t gives dma_valid_o high at t+1. Peak throughput is one job per 2 cycles.
- Completion:
  - dma_done_i with FIFO non-empty pops the head index h; cmpl_o[h] = 1 in the next cycle (registered); outstanding -= 1.
  - dma_done_i with FIFO empty: ignored, err_o set, counters unchanged.
- Simultaneous accept and done in one cycle: push and pop both happen; outstanding unchanged; the FIFO never overflows because depth = MaxOutstanding.
- Full (outstanding == MaxOutstanding): no grants. A done in the same cycle does not enable a grant until the next cycle.
- drain_i asserted during ISSUE: the pending job still completes its handshake; there are no further grants.
- Deasserting drain_i resumes arbitration; done_o falls combinationally.
- Reset mid-operation: in-flight jobs are forgotten and late dma_done_i pulses set err_o. The bench must not do this except in the reset test.
- Counter width rule: outstanding is $clog2(MaxOutstanding+1) bits; the FIFO pointer is $clog2(MaxOutstanding) bits (minimum 1) and wraps.

Decomposition:
- Shared test package dma_arb_pkg:
  - dma_job_t struct {src, dst, len}.
  - Default widths.
  - rr_next function.
- Sub-module dma_arb_idx_fifo: index FIFO, depth MaxOutstanding, width $clog2(NumReq), push/pop/full/empty, same clock and reset.

Test Plan:
- Single job: requester 2 sends src=0x1000, dst=0x2000, len=64 with dma_ready_i=1 → dma_valid_o high 1 cycle after the handshake with the same payload. Then dma_done_i → cmpl_o=4'b0100 one cycle later; issued_cnt_o=1; busy_o back to 0.
- Fairness: all 4 requesters valid continuously, dma_ready_i=1, dma_done_i pulsed after each issue → grant order 0,1,2,3,0,1…; 8 jobs in 16 cycles.
- Backpressure: dma_ready_i low for 5 cycles → dma_valid_o and payload stable throughout; req_ready_o=0; one transfer when ready rises.
- Outstanding limit: MaxOutstanding=4, no dma_done_i → exactly 4 jobs accepted, then req_ready_o=0. One dma_done_i → a 5th job is accepted the cycle after. Simultaneous accept and done keeps outstanding at 4.
- Drain: drain_i raised with 2 jobs outstanding → no grants; done_o=0 until the second dma_done_i, then done_o=1.
- Error and reset: dma_done_i with nothing outstanding → err_o=1 and sticky. rst_ni low for 1 cycle mid-ISSUE → all outputs 0 the next cycle and the rr pointer restarts at requester 0.
